// File: rtl/alu_seq_exec.sv
// alu_seq_exec: execute-stage ALU with valid/ready command input and valid/ready registered result.
// Define ALU_SRA_BARREL_EN for a single-cycle barrel sra; default is an iterative 1-bit/cycle sra.
module alu_seq_exec #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       alu_control,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_SLT = 3'b101;
   localparam logic [2:0] OP_SRA = 3'b110;

`ifdef ALU_SRA_BARREL_EN
   typedef enum logic [1:0] {IDLE, DONE} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

   state_t             state;
   logic [SHAMT_W-1:0] shamt;
   logic               accept;
   logic [WIDTH-1:0]   op_result;
   logic               op_illegal;

`ifndef ALU_SRA_BARREL_EN
   logic               op_iterate;
   logic [WIDTH-1:0]   shift_q;
   logic [WIDTH-1:0]   shift_next;
   logic [SHAMT_W-1:0] count_q;

   assign shift_next = {shift_q[WIDTH-1], shift_q[WIDTH-1:1]};
`endif

   assign shamt  = src_b[SHAMT_W-1:0];
   assign accept = in_valid && in_ready;

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      op_result  = '0;
      op_illegal = 1'b0;
`ifndef ALU_SRA_BARREL_EN
      op_iterate = 1'b0;
`endif
      case (alu_control)
         OP_ADD: op_result = src_a + src_b;
         OP_SUB: op_result = src_a - src_b;
         OP_AND: op_result = src_a & src_b;
         OP_OR:  op_result = src_a | src_b;
         OP_SLT: op_result = {{(WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
         OP_SRA: begin
`ifdef ALU_SRA_BARREL_EN
            op_result = $signed(src_a) >>> shamt;
`else
            // shamt 0 completes immediately with the unshifted operand
            op_result  = src_a;
            op_iterate = (shamt != '0);
`endif
         end
         default: op_illegal = 1'b1;
      endcase
   end

   // DONE accepts only when the pending result is consumed in the same cycle
   always_comb begin
      case (state)
         IDLE:    in_ready = 1'b1;
         DONE:    in_ready = out_ready;
         default: in_ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      if (!rst_n) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b0;
         illegal   <= 1'b0;
`ifndef ALU_SRA_BARREL_EN
         shift_q   <= '0;
         count_q   <= '0;
`endif
      end else if (accept) begin
`ifndef ALU_SRA_BARREL_EN
         if (op_iterate) begin
            state     <= SHIFT;
            out_valid <= 1'b0;
            shift_q   <= src_a;
            count_q   <= shamt;
         end else
`endif
         begin
            state     <= DONE;
            out_valid <= 1'b1;
            result    <= op_result;
            zero      <= (op_result == '0);
            illegal   <= op_illegal;
         end
      end else begin
         case (state)
`ifndef ALU_SRA_BARREL_EN
            SHIFT: begin
               shift_q <= shift_next;
               count_q <= count_q - SHAMT_W'(1);
               if (count_q == SHAMT_W'(1)) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  result    <= shift_next;
                  zero      <= (shift_next == '0);
                  illegal   <= 1'b0;
               end
            end
`endif
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq_exec.sv
// tb_alu_seq_exec: directed stimulus for alu_seq_exec, checked every cycle against a
// transaction-level model (countdown latency + arithmetic), plus hand-computed literals.
module tb_alu_seq_exec;

   localparam logic [2:0] ADD = 3'b000, SUB = 3'b001, AND_ = 3'b010, OR_ = 3'b011,
                          SLT = 3'b101, SRA = 3'b110, ILL0 = 3'b100, ILL1 = 3'b111;
`ifdef ALU_SRA_BARREL_EN
   localparam bit BARREL = 1'b1;
`else
   localparam bit BARREL = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n, in_valid, out_ready;
   logic [2:0]  alu_control;
   logic [31:0] src_a, src_b;
   logic        in_ready, out_valid, zero, illegal;
   logic [31:0] result;

   int n_checks = 0;
   int n_fail   = 0;

   alu_seq_exec #(.WIDTH(32), .SHAMT_W(5)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .alu_control(alu_control), .src_a(src_a), .src_b(src_b),
      .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .zero(zero), .illegal(illegal)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic void model_alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] r, output logic ill, output int lat);
      ill = 1'b0;
      lat = 1;
      case (c)
         ADD:  r = a + b;
         SUB:  r = a - b;
         AND_: r = a & b;
         OR_:  r = a | b;
         SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         SRA: begin
            r = $signed(a) >>> b[4:0];
            if (!BARREL) lat = 1 + int'(b[4:0]);
         end
         default: begin r = 32'd0; ill = 1'b1; end
      endcase
   endfunction

   logic        m_on = 1'b0;
   logic        m_valid, m_zero, m_ill, m_rst_view, m_acc, m_il;
   logic [31:0] m_res, p_res, m_r;
   int          m_wait, m_lat;

   function automatic logic m_ready();
      return (m_wait == 0) && (!m_valid || out_ready);
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_on = 1'b1; m_valid = 1'b0; m_res = '0; m_zero = 1'b0; m_ill = 1'b0;
         m_wait = 0; m_rst_view = 1'b1;
      end else if (m_on) begin
         m_acc = in_valid && m_ready();
         if (m_valid && out_ready) m_valid = 1'b0;
         if (m_wait > 0) begin
            m_wait--;
            if (m_wait == 0) begin
               m_valid = 1'b1; m_res = p_res; m_zero = (p_res == 0); m_ill = 1'b0;
            end
         end
         if (m_acc) begin
            model_alu(alu_control, src_a, src_b, m_r, m_il, m_lat);
            m_rst_view = 1'b0;
            if (m_lat == 1) begin
               m_valid = 1'b1; m_res = m_r; m_zero = (m_r == 0); m_ill = m_il;
            end else begin
               m_wait = m_lat - 1; p_res = m_r;
            end
         end
      end
   end

   // compare process: every cycle once reset has been applied
   always @(negedge clk) begin
      #1;
      if (m_on) begin
         check("out_valid", 32'(out_valid), 32'(m_valid));
         check("in_ready", 32'(in_ready), 32'(m_ready()));
         if (m_valid || m_rst_view) begin
            check("result", result, m_res);
            check("zero", 32'(zero), 32'(m_zero));
            check("illegal", 32'(illegal), 32'(m_ill));
         end
      end
   end

   // ---------------- driver helpers ----------------
   task automatic idle(input int n);
      repeat (n) begin @(negedge clk); #1; end
   endtask

   // Present a command and hold it until accepted; scramble inputs afterwards.
   task automatic send(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
      int k;
      in_valid = 1'b1; alu_control = c; src_a = a; src_b = b;
      #1;
      for (k = 0; k < 100 && !in_ready; k++) begin @(negedge clk); #1; end
      if (!in_ready) begin
         check("accept_timeout", 32'd0, 32'd1);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      @(negedge clk); #1;
      in_valid = 1'b0; alu_control = 3'($urandom); src_a = $urandom; src_b = $urandom;
   endtask

   // Called right after send: counts posedges since the accept edge until out_valid.
   task automatic wait_result(output int cyc);
      cyc = 1;
      while (!out_valid && cyc < 64) begin @(negedge clk); #1; cyc++; end
      if (!out_valid) check("result_timeout", 32'd0, 32'd1);
   endtask

   task automatic expect_out(input string name, input logic [31:0] r, input logic z, input logic il);
      check({name, "_res"}, result, r);
      check({name, "_zero"}, 32'(zero), 32'(z));
      check({name, "_ill"}, 32'(illegal), 32'(il));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      alu_control = ADD; src_a = '0; src_b = '0;
      idle(2);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      expect_out("rst", 32'd0, 1'b0, 1'b0);
      rst_n = 1'b1;
      idle(1);

      // basic arithmetic
      send(ADD, 32'd5, 32'd7); wait_result(cyc);
      check("add_lat", cyc, 32'd1); expect_out("add", 32'd12, 1'b0, 1'b0);
      send(SUB, 32'd5, 32'd5); wait_result(cyc);
      expect_out("sub", 32'd0, 1'b1, 1'b0);
      send(SLT, 32'hFFFF_FFFF, 32'd1); wait_result(cyc);
      expect_out("slt_neg", 32'd1, 1'b0, 1'b0);
      send(SLT, 32'd1, 32'hFFFF_FFFF); wait_result(cyc);
      expect_out("slt_pos", 32'd0, 1'b1, 1'b0);
      send(ADD, 32'hFFFF_FFFF, 32'd1); wait_result(cyc);
      expect_out("add_wrap", 32'd0, 1'b1, 1'b0);
      send(SUB, 32'd0, 32'd1); wait_result(cyc);
      expect_out("sub_wrap", 32'hFFFF_FFFF, 1'b0, 1'b0);
      send(AND_, 32'hFF00_FF00, 32'h0FF0_0FF0); wait_result(cyc);
      expect_out("and", 32'h0F00_0F00, 1'b0, 1'b0);

      // sra: latency, busy, shamt 0 and max
      send(SRA, 32'h8000_0000, 32'd4);
      if (!BARREL) check("sra_busy", 32'(in_ready), 32'd0);
      wait_result(cyc);
      check("sra_lat", cyc, BARREL ? 32'd1 : 32'd5);
      expect_out("sra4", 32'hF800_0000, 1'b0, 1'b0);
      send(SRA, 32'h1234_5678, 32'h20); wait_result(cyc);
      check("sra0_lat", cyc, 32'd1); expect_out("sra0", 32'h1234_5678, 1'b0, 1'b0);
      send(SRA, 32'h8000_0000, 32'd31); wait_result(cyc);
      check("sra31_lat", cyc, BARREL ? 32'd1 : 32'd32);
      expect_out("sra31", 32'hFFFF_FFFF, 1'b0, 1'b0);
      // a command presented while shifting must wait for the result to be taken
      send(SRA, 32'h7000_0000, 32'd3);
      send(ADD, 32'd1, 32'd2); wait_result(cyc);
      expect_out("add_after_sra", 32'd3, 1'b0, 1'b0);
      idle(1);

      // backpressure then back-to-back accept on consume
      out_ready = 1'b0;
      send(SUB, 32'd9, 32'd2); wait_result(cyc);
      for (int i = 0; i < 3; i++) begin
         idle(1);
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         check("bp_res", result, 32'd7);
      end
      out_ready = 1'b1;
      send(OR_, 32'h0000_00F0, 32'h0000_000F);
      check("b2b_valid", 32'(out_valid), 32'd1);
      expect_out("or", 32'h0000_00FF, 1'b0, 1'b0);
      idle(1);

      // reset mid-shift
      send(SRA, 32'hF000_0000, 32'd20);
      idle(1);
      @(negedge clk); #1 rst_n = 1'b0;
      @(negedge clk); #1 rst_n = 1'b1;
      check("rstmid_valid", 32'(out_valid), 32'd0);
      check("rstmid_res", result, 32'd0);
      check("rstmid_in_ready", 32'(in_ready), 32'd1);
      send(ADD, 32'd2, 32'd3); wait_result(cyc);
      check("rstmid_add_lat", cyc, 32'd1); expect_out("rstmid_add", 32'd5, 1'b0, 1'b0);

      // illegal codes
      send(ILL0, 32'd3, 32'd4); wait_result(cyc);
      check("ill0_lat", cyc, 32'd1); expect_out("ill0", 32'd0, 1'b1, 1'b1);
      send(ILL1, 32'd8, 32'd9); wait_result(cyc);
      expect_out("ill1", 32'd0, 1'b1, 1'b1);
      send(OR_, 32'd3, 32'd4); wait_result(cyc);
      expect_out("ill_clear", 32'd7, 1'b0, 1'b0);

      idle(3);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
